// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs a single-outstanding req/ack
// port to instruction memory and feeds IF/ID with backpressure and redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        branch_taken_i,
  input  logic [31:0] pc_branch_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DROP, S_HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        req_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;
  logic        misalign_q;
  logic        halt_pend_q;

  logic        ack;
  logic        consume;
  logic        can_accept;
  logic        target_misaligned;
  logic [31:0] pc_inc;

  assign ack               = imem_ack_i && req_q;
  assign consume           = out_valid_q && !stall_i;
  assign can_accept        = !out_valid_q || !stall_i;
  assign target_misaligned = pc_branch_i[1:0] != 2'b00;
  assign pc_inc            = pc_q + 32'd4;

  assign flush_o     = branch_taken_i && (state_q != S_HALT);
  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = out_valid_q;
  assign if_instr_o  = out_instr_q;
  assign if_pc_o     = out_pc_q;
  assign misalign_o  = misalign_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      misalign_q   <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end

        S_REQ, S_HOLD, S_DROP: begin
          if (branch_taken_i) begin
            // The hold buffer is emptied simply by leaving HOLD.
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            pc_q        <= pc_branch_i;
            if (target_misaligned) begin
              misalign_q  <= 1'b1;
              halt_pend_q <= 1'b1;
            end
            if (req_q && !imem_ack_i) begin
              state_q <= S_DROP;
            end else if (target_misaligned || halt_pend_q) begin
              state_q <= S_HALT;
              req_q   <= 1'b0;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_branch_i;
            end
          end else begin
            if (consume) begin
              out_valid_q <= 1'b0;
              out_instr_q <= NOP_INSTR;
            end
            case (state_q)
              S_REQ: begin
                if (ack) begin
                  pc_q   <= pc_inc;
                  addr_q <= pc_inc;
                  if (can_accept) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= imem_rdata_i;
                    out_pc_q    <= pc_q;
                  end else begin
                    hold_instr_q <= imem_rdata_i;
                    hold_pc_q    <= pc_q;
                    state_q      <= S_HOLD;
                    req_q        <= 1'b0;
                  end
                end
              end
              S_HOLD: begin
                if (!stall_i) begin
                  out_valid_q <= 1'b1;
                  out_instr_q <= hold_instr_q;
                  out_pc_q    <= hold_pc_q;
                  state_q     <= S_REQ;
                  req_q       <= 1'b1;
                  addr_q      <= pc_q;
                end
              end
              default: begin
                // DROP: the stale word is discarded; pc_q already holds the target.
                if (ack) begin
                  if (halt_pend_q) begin
                    state_q <= S_HALT;
                    req_q   <= 1'b0;
                  end else begin
                    state_q <= S_REQ;
                    addr_q  <= pc_q;
                  end
                end
              end
            endcase
          end
        end

        S_HALT: begin
          req_q       <= 1'b0;
          out_valid_q <= 1'b0;
          out_instr_q <= NOP_INSTR;
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
